// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/half/word little-endian access on an internal word RAM
// with fixed latency and a valid/ready response. Define DATA_MEM_MISALIGN_TRAP_EN to trap misaligned accesses.

package data_mem_responder_pkg;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_ctrl_t;
endpackage

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_do_read_ctrl,
  input  logic        mem_do_write_ctrl,
  input  mem_ctrl_t   mem_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned BW = AW + 2;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] addr_q;
  mem_ctrl_t     ctrl_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          err_q;
  logic          req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          latch_c;

  logic [31:0]   mem [DEPTH_WORDS];

  // Request decode at accept time: legality, alignment and effective address
  logic          is_load_c, is_store_c, half_c, word_c, misalign_c, illegal_c;
  logic          acc_err_c;
  logic [BW-1:0] acc_addr_c;
  logic          unused_addr_c;

  assign unused_addr_c = ^req_addr[31:BW];

  always_comb begin
    is_load_c  = (mem_ctrl == MEM_LB) || (mem_ctrl == MEM_LH) || (mem_ctrl == MEM_LW) ||
                 (mem_ctrl == MEM_LBU) || (mem_ctrl == MEM_LHU);
    is_store_c = (mem_ctrl == MEM_SB) || (mem_ctrl == MEM_SH) || (mem_ctrl == MEM_SW);
    half_c     = (mem_ctrl == MEM_LH) || (mem_ctrl == MEM_LHU) || (mem_ctrl == MEM_SH);
    word_c     = (mem_ctrl == MEM_LW) || (mem_ctrl == MEM_SW);
    misalign_c = (half_c && req_addr[0]) || (word_c && (req_addr[1:0] != 2'b00));
    illegal_c  = (mem_ctrl == MEM_NOP) || (mem_do_write_ctrl ? !is_store_c : !is_load_c);
    acc_addr_c = req_addr[BW-1:0];
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    acc_err_c  = illegal_c || misalign_c;
`else
    acc_err_c  = illegal_c;
    if (half_c) acc_addr_c[0] = 1'b0;
    if (word_c) acc_addr_c[1:0] = 2'b00;
`endif
  end

  // Lane selection on the latched request
  logic [AW-1:0] idx_c;
  logic [31:0]   rd_word_c, load_data_c, wlane_c;
  logic [7:0]    rd_byte_c;
  logic [15:0]   rd_half_c;
  logic [3:0]    be_c;
  logic          commit_c, mem_we_c;

  assign idx_c     = addr_q[BW-1:2];
  assign rd_word_c = mem[idx_c];
  assign rd_half_c = addr_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte_c = rd_word_c[7:0];
      2'd1:    rd_byte_c = rd_word_c[15:8];
      2'd2:    rd_byte_c = rd_word_c[23:16];
      default: rd_byte_c = rd_word_c[31:24];
    endcase
  end

  always_comb begin
    load_data_c = '0;
    be_c        = '0;
    wlane_c     = wdata_q;
    case (ctrl_q)
      MEM_LB:  load_data_c = {{24{rd_byte_c[7]}}, rd_byte_c};
      MEM_LBU: load_data_c = {24'd0, rd_byte_c};
      MEM_LH:  load_data_c = {{16{rd_half_c[15]}}, rd_half_c};
      MEM_LHU: load_data_c = {16'd0, rd_half_c};
      MEM_LW:  load_data_c = rd_word_c;
      MEM_SB: begin
        be_c    = 4'(4'b0001 << addr_q[1:0]);
        wlane_c = {4{wdata_q[7:0]}};
      end
      MEM_SH: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      MEM_SW:  be_c = 4'b1111;
      default: load_data_c = '0;
    endcase
  end

  assign commit_c = (state_q == ST_BUSY) && (cnt_q == '0);
  assign mem_we_c = commit_c && write_q && !err_q;

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    latch_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (mem_do_read_ctrl || mem_do_write_ctrl)) begin
          latch_c     = 1'b1;
          state_d     = ST_BUSY;
          cnt_d       = CW'(LATENCY - 1);
          req_ready_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (!write_q && !err_q) ? load_data_c : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      ctrl_q    <= MEM_NOP;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (latch_c) begin
        addr_q  <= acc_addr_c;
        ctrl_q  <= mem_ctrl;
        wdata_q <= req_wdata;
        write_q <= mem_do_write_ctrl;
        err_q   <= acc_err_c;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed steps plus randomized traffic against a byte-array reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_do_read_ctrl = 1'b0;
  logic        mem_do_write_ctrl = 1'b0;
  mem_ctrl_t   mem_ctrl = MEM_NOP;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_mem [NBYTES];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_do_read_ctrl(mem_do_read_ctrl), .mem_do_write_ctrl(mem_do_write_ctrl),
    .mem_ctrl(mem_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: size, legality and alignment from the access rules, memory as a flat byte array
  function automatic void model(input mem_ctrl_t c, input logic wr, input logic [31:0] a_in,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned size, base;
    logic [31:0] a, v;
    bit is_ld, is_st;
    a     = a_in;
    rd    = '0;
    is_st = (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW);
    is_ld = (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW) || (c == MEM_LBU) || (c == MEM_LHU);
    size  = (c == MEM_LH || c == MEM_LHU || c == MEM_SH) ? 2 :
            (c == MEM_LW || c == MEM_SW) ? 4 : 1;
    err   = (c == MEM_NOP) || (wr ? !is_st : !is_ld);
    if (err) return;
    if ((a % size) != 0) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      err = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    base = a % NBYTES;
    if (wr) begin
      for (int i = 0; i < int'(size); i++) model_mem[base + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(size); i++) v = v | (32'(model_mem[base + i]) << (8 * i));
      if (c == MEM_LB && v[7])  v = v | 32'hFFFF_FF00;
      if (c == MEM_LH && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, ":rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  task automatic xact(input mem_ctrl_t c, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      input string tag, input bit use_lit = 1'b0,
                      input logic [31:0] lit_rd = '0, input logic lit_err = 1'b0);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    model(c, wr, a, wd, exp_rd, exp_err);
    if (use_lit) begin
      exp_rd  = lit_rd;
      exp_err = lit_err;
    end
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; mem_ctrl = c; mem_do_read_ctrl = rd; mem_do_write_ctrl = wr;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; mem_do_read_ctrl = 1'b0; mem_do_write_ctrl = 1'b0;
    check({tag, ":busy_ready"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(LAT));
    check({tag, ":rdata"}, rsp_rdata, exp_rd);
    check({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
    // A competing store offered while the response is held must not be taken
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; mem_ctrl = MEM_SW; mem_do_write_ctrl = 1'b1;
      req_addr = 32'h0000_0004; req_wdata = 32'h5A5A_5A5A;
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ":hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; mem_do_write_ctrl = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ":ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 16; w++) xact(MEM_SW, 1'b0, 1'b1, 32'(w * 4), $urandom(), 0, "init");

    xact(MEM_SW,  1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, "sw10",  1'b1, 32'h0, 1'b0);
    xact(MEM_LW,  1'b1, 1'b0, 32'h10, 32'h0, 0, "lw10",  1'b1, 32'hDEAD_BEEF, 1'b0);
    xact(MEM_SB,  1'b0, 1'b1, 32'h11, 32'h0000_007F, 0, "sb11", 1'b1, 32'h0, 1'b0);
    xact(MEM_LB,  1'b1, 1'b0, 32'h11, 32'h0, 0, "lb11",  1'b1, 32'h0000_007F, 1'b0);
    xact(MEM_LBU, 1'b1, 1'b0, 32'h13, 32'h0, 0, "lbu13", 1'b1, 32'h0000_00DE, 1'b0);
    xact(MEM_LB,  1'b1, 1'b0, 32'h13, 32'h0, 0, "lb13",  1'b1, 32'hFFFF_FFDE, 1'b0);
    xact(MEM_SH,  1'b0, 1'b1, 32'h12, 32'h0000_8001, 0, "sh12", 1'b1, 32'h0, 1'b0);
    xact(MEM_LH,  1'b1, 1'b0, 32'h12, 32'h0, 0, "lh12",  1'b1, 32'hFFFF_8001, 1'b0);
    xact(MEM_LHU, 1'b1, 1'b0, 32'h12, 32'h0, 0, "lhu12", 1'b1, 32'h0000_8001, 1'b0);
    xact(MEM_LW,  1'b1, 1'b0, 32'h10, 32'h0, 0, "lw10b", 1'b1, 32'h8001_7FEF, 1'b0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    xact(MEM_LW,  1'b1, 1'b0, 32'h12, 32'h0, 0, "lw12_mis", 1'b1, 32'h0, 1'b1);
`else
    xact(MEM_LW,  1'b1, 1'b0, 32'h12, 32'h0, 0, "lw12_mis", 1'b1, 32'h8001_7FEF, 1'b0);
`endif
    xact(MEM_LW,  1'b1, 1'b0, 32'h10, 32'h0, 5, "hold5", 1'b1, 32'h8001_7FEF, 1'b0);
    xact(MEM_LW,  1'b1, 1'b0, 32'h04, 32'h0, 0, "no_stray_sw");

    xact(MEM_SW,  1'b1, 1'b1, 32'h14, 32'h1122_3344, 0, "rw_both", 1'b1, 32'h0, 1'b0);
    xact(MEM_LW,  1'b1, 1'b0, 32'h14, 32'h0, 0, "lw14", 1'b1, 32'h1122_3344, 1'b0);

    // Request with neither direction set is ignored
    req_valid = 1'b1; mem_ctrl = MEM_LW; req_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ignored:req_ready", 32'(req_ready), 32'd1);
      check("ignored:rsp_valid", 32'(rsp_valid), 32'd0);
    end
    req_valid = 1'b0;

    // Reset during BUSY discards the uncommitted store
    xact(MEM_SW, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, "sw20");
    req_valid = 1'b1; mem_ctrl = MEM_SW; mem_do_write_ctrl = 1'b1;
    req_addr = 32'h20; req_wdata = 32'h0000_0001;
    @(negedge clk);
    req_valid = 1'b0; mem_do_write_ctrl = 1'b0;
    check("rst_mid:busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(MEM_LW, 1'b1, 1'b0, 32'h20, 32'h0, 0, "lw20_after_rst", 1'b1, 32'hCAFE_F00D, 1'b0);

    xact(MEM_LW,  1'b0, 1'b1, 32'h24, 32'hFFFF_FFFF, 0, "wr_with_lw", 1'b1, 32'h0, 1'b1);
    xact(MEM_LW,  1'b1, 1'b0, 32'h24, 32'h0, 0, "lw24");
    xact(MEM_SB,  1'b1, 1'b0, 32'h24, 32'h0, 0, "rd_with_sb", 1'b1, 32'h0, 1'b1);
    xact(MEM_NOP, 1'b1, 1'b0, 32'h24, 32'h0, 0, "nop", 1'b1, 32'h0, 1'b1);
    xact(MEM_LW,  1'b1, 1'b0, 32'(NBYTES), 32'h0, 0, "alias0");

    for (int k = 0; k < 60; k++) begin
      ra  = ($urandom() & ~32'(NBYTES - 1)) | 32'($urandom_range(0, 63));
      sel = int'($urandom_range(0, 2));
      xact(mem_ctrl_t'(4'($urandom_range(0, 8))), sel != 1, sel != 0, ra, $urandom(),
           int'($urandom_range(0, 2)), "rand");
    end
    for (int w = 0; w < 16; w++) xact(MEM_LW, 1'b1, 1'b0, 32'(w * 4), 32'h0, 0, "sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
